ltc_tc_sequencer: RTL and testbench

- Owns the running BCD timecode that feeds the LTC frame serializer.
- Arbitrates three update sources: frame advance ticks, a preset/jam load handshake, and manual sec/min/hrs increment pulses.
- Frame advances ripple the carry through frames→secs→mins→hrs, one field per cycle.
- Framerate changes are applied only at second boundaries, and a stable snapshot strobe is issued after every commit.

---
 rtl/ltc_pkg.sv | 62 ++++++
 rtl/ltc_bcd_inc.sv | 26 ++
 rtl/ltc_tc_sequencer.sv | 245 ++++++++++++++++++++++++
 tb/tb_ltc_tc_sequencer.sv | 483 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ltc_pkg.sv
// Shared definitions for the LTC timecode sequencer.
// Contents:
//   - framerate encodings and the max-frame decode for each rate
//   - BCD field limits for seconds, minutes and hours
//   - bit offsets and widths of the packed timecode {hrs, min, sec, frm}
//   - the sequencer FSM state enum and the incrementer field-select enum
//   - bcd_ok(): digit and limit check used when validating a preset
package ltc_pkg;

    localparam logic [1:0] FR_24   = 2'b00;
    localparam logic [1:0] FR_25   = 2'b01;
    localparam logic [1:0] FR_RSVD = 2'b10;
    localparam logic [1:0] FR_30   = 2'b11;

    // Field limits as two-digit BCD values.
    localparam logic [7:0] SEC_MAX = 8'h59;
    localparam logic [7:0] MIN_MAX = 8'h59;
    localparam logic [7:0] HRS_MAX = 8'h23;

    // Packed timecode layout: {hrs[5:0], min[6:0], sec[6:0], frm[5:0]}.
    localparam int TC_W    = 26;
    localparam int FRM_LSB = 0;
    localparam int FRM_W   = 6;
    localparam int SEC_LSB = 6;
    localparam int SEC_W   = 7;
    localparam int MIN_LSB = 13;
    localparam int MIN_W   = 7;
    localparam int HRS_LSB = 20;
    localparam int HRS_W   = 6;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADV_FRM = 3'd1,
        ST_ADV_SEC = 3'd2,
        ST_ADV_MIN = 3'd3,
        ST_ADV_HRS = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        FLD_FRM = 2'd0,
        FLD_SEC = 2'd1,
        FLD_MIN = 2'd2,
        FLD_HRS = 2'd3
    } field_t;

    // Highest frame number (BCD) for a framerate code. The reserved code
    // never reaches the active-rate register, so its entry is never used.
    function automatic logic [7:0] max_frame(input logic [1:0] fr);
        case (fr)
            FR_24:   return 8'h23;
            FR_30:   return 8'h29;
            default: return 8'h24;
        endcase
    endfunction

    // With the units digit known to be 0..9, plain unsigned compare on the
    // BCD byte orders the same way as the decimal value.
    function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] lim);
        return (v[3:0] <= 4'd9) && (v <= lim);
    endfunction

endpackage

// File: rtl/ltc_bcd_inc.sv
// Two-digit BCD incrementer with a wrap limit (combinational).
// Ports:
//   value  in  8  current value, {tens[3:0], units[3:0]}
//   limit  in  8  highest legal value; at or above it the result wraps to 00
//   next   out 7  incremented value, {tens[2:0], units[3:0]}
//   wrap   out 1  value was at the limit and has wrapped to 00
module ltc_bcd_inc (
    input  logic [7:0] value,
    input  logic [7:0] limit,
    output logic [6:0] next,
    output logic       wrap
);

    always_comb begin
        next = 7'h00;
        wrap = 1'b0;
        if (value >= limit) begin
            wrap = 1'b1;
        end else if (value[3:0] >= 4'd9) begin
            next = {value[6:4] + 3'd1, 4'd0};
        end else begin
            next = {value[6:4], value[3:0] + 4'd1};
        end
    end

endmodule

// File: rtl/ltc_tc_sequencer.sv
// Running BCD timecode for the LTC frame serializer.
// Three update sources share one BCD incrementer:
//   - frame_tick: latched into tick_pend, then the carry ripples
//     frm -> sec -> min -> hrs, one field per cycle
//   - preset handshake: validated, then loaded whole or rejected
//   - inc_sec / inc_min / inc_hrs: latched, serviced one per idle cycle
// Ports:
//   sys_clk       in  1   system clock
//   reset         in  1   synchronous, active-high reset
//   framerate     in  2   requested rate; taken only at a second boundary
//   frame_tick    in  1   one-cycle pulse, advance one frame
//   preset_valid  in  1   preset request
//   preset_ready  out 1   preset taken on a cycle with valid & ready
//   preset_tc     in  26  preset value {hrs, min, sec, frm}, packed BCD
//   inc_sec/min/hrs in 1  manual increment pulses
//   tc_out        out 26  current timecode
//   fr_active     out 2   framerate in effect
//   tc_update     out 1   one-cycle pulse the cycle after every commit
//   busy          out 1   carry chain in progress (FSM not idle)
//   preset_err    out 1   one-cycle pulse, preset rejected
//   state_dbg     out 3   FSM state encoding, for observation only
module ltc_tc_sequencer
    import ltc_pkg::*;
#(
    parameter logic [1:0] FR_DEFAULT = 2'b01
) (
    input  logic            sys_clk,
    input  logic            reset,
    input  logic [1:0]      framerate,
    input  logic            frame_tick,
    input  logic            preset_valid,
    output logic            preset_ready,
    input  logic [TC_W-1:0] preset_tc,
    input  logic            inc_sec,
    input  logic            inc_min,
    input  logic            inc_hrs,
    output logic [TC_W-1:0] tc_out,
    output logic [1:0]      fr_active,
    output logic            tc_update,
    output logic            busy,
    output logic            preset_err,
    output logic [2:0]      state_dbg
);

    state_t          state, state_n;
    logic            tick_pend;
    logic            pend_sec, pend_min, pend_hrs;
    logic [TC_W-1:0] tc_q;
    logic [1:0]      fr_q;
    logic            tc_update_q;
    logic            preset_err_q;

    // Control decoded from the state.
    logic            ready;
    logic            accept;
    logic            take_tick;
    logic            svc_sec, svc_min, svc_hrs;
    logic            wr_en;
    logic            commit;
    logic            load_fr;
    field_t          fld;

    // Shared incrementer.
    logic [7:0]      inc_in;
    logic [7:0]      inc_lim;
    logic [6:0]      inc_next;
    logic            inc_wrap;
    logic [TC_W-1:0] tc_wr;
    logic            preset_good;

    ltc_bcd_inc u_bcd_inc (
        .value (inc_in),
        .limit (inc_lim),
        .next  (inc_next),
        .wrap  (inc_wrap)
    );

    // Handshake: a preset is consumed on any cycle where preset_valid and
    // preset_ready are both high, whether or not it turns out valid.
    // preset_ready depends only on state and tick_pend, never on valid.
    assign ready  = (state == ST_IDLE) && !tick_pend && !reset;
    assign accept = ready && preset_valid;

    assign preset_good =
        bcd_ok({2'b00, preset_tc[FRM_LSB +: FRM_W]}, max_frame(fr_q)) &&
        bcd_ok({1'b0,  preset_tc[SEC_LSB +: SEC_W]}, SEC_MAX) &&
        bcd_ok({1'b0,  preset_tc[MIN_LSB +: MIN_W]}, MIN_MAX) &&
        bcd_ok({2'b00, preset_tc[HRS_LSB +: HRS_W]}, HRS_MAX);

    // State register.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic. A wrap in one field moves on to the next field.
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:    if (tick_pend) state_n = ST_ADV_FRM;
            ST_ADV_FRM: state_n = inc_wrap ? ST_ADV_SEC : ST_IDLE;
            ST_ADV_SEC: state_n = inc_wrap ? ST_ADV_MIN : ST_IDLE;
            ST_ADV_MIN: state_n = inc_wrap ? ST_ADV_HRS : ST_IDLE;
            ST_ADV_HRS: state_n = ST_IDLE;
            default:    state_n = ST_IDLE;
        endcase
    end

    // Field select for the shared incrementer. Kept apart from the control
    // decode below because that decode depends on the incrementer's wrap.
    always_comb begin
        fld     = FLD_FRM;
        svc_sec = 1'b0;
        svc_min = 1'b0;
        svc_hrs = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!tick_pend && !accept) begin
                    if (pend_sec) begin
                        svc_sec = 1'b1;
                        fld     = FLD_SEC;
                    end else if (pend_min) begin
                        svc_min = 1'b1;
                        fld     = FLD_MIN;
                    end else if (pend_hrs) begin
                        svc_hrs = 1'b1;
                        fld     = FLD_HRS;
                    end
                end
            end
            ST_ADV_FRM: fld = FLD_FRM;
            ST_ADV_SEC: fld = FLD_SEC;
            ST_ADV_MIN: fld = FLD_MIN;
            ST_ADV_HRS: fld = FLD_HRS;
            default:    fld = FLD_FRM;
        endcase
    end

    // Output / control decode. A chain commits only in its last field, so
    // tc_update never fires mid-chain.
    always_comb begin
        take_tick = 1'b0;
        wr_en     = 1'b0;
        commit    = 1'b0;
        load_fr   = 1'b0;
        case (state)
            ST_IDLE: begin
                take_tick = tick_pend;
                if (svc_sec || svc_min || svc_hrs) begin
                    wr_en  = 1'b1;
                    commit = 1'b1;
                end else if (accept && preset_good) begin
                    commit = 1'b1;
                end
            end
            ST_ADV_FRM: begin
                wr_en   = 1'b1;
                commit  = !inc_wrap;
                load_fr = inc_wrap;
            end
            ST_ADV_SEC, ST_ADV_MIN: begin
                wr_en  = 1'b1;
                commit = !inc_wrap;
            end
            ST_ADV_HRS: begin
                wr_en  = 1'b1;
                commit = 1'b1;
            end
            default: begin
                wr_en = 1'b0;
            end
        endcase
    end

    // Incrementer operand mux and write-back into the selected field.
    always_comb begin
        inc_in  = 8'h00;
        inc_lim = SEC_MAX;
        tc_wr   = tc_q;
        case (fld)
            FLD_FRM: begin
                inc_in  = {2'b00, tc_q[FRM_LSB +: FRM_W]};
                inc_lim = max_frame(fr_q);
                tc_wr[FRM_LSB +: FRM_W] = inc_next[FRM_W-1:0];
            end
            FLD_SEC: begin
                inc_in  = {1'b0, tc_q[SEC_LSB +: SEC_W]};
                inc_lim = SEC_MAX;
                tc_wr[SEC_LSB +: SEC_W] = inc_next;
            end
            FLD_MIN: begin
                inc_in  = {1'b0, tc_q[MIN_LSB +: MIN_W]};
                inc_lim = MIN_MAX;
                tc_wr[MIN_LSB +: MIN_W] = inc_next;
            end
            default: begin
                inc_in  = {2'b00, tc_q[HRS_LSB +: HRS_W]};
                inc_lim = HRS_MAX;
                tc_wr[HRS_LSB +: HRS_W] = inc_next[HRS_W-1:0];
            end
        endcase
    end

    // Datapath and pending flags. A new pulse always sets its flag, even on
    // the cycle the old request is being taken, so nothing is dropped.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            tick_pend    <= 1'b0;
            pend_sec     <= 1'b0;
            pend_min     <= 1'b0;
            pend_hrs     <= 1'b0;
            tc_q         <= '0;
            fr_q         <= FR_DEFAULT;
            tc_update_q  <= 1'b0;
            preset_err_q <= 1'b0;
        end else begin
            tick_pend <= frame_tick | (tick_pend & ~take_tick);
            pend_sec  <= inc_sec    | (pend_sec  & ~svc_sec);
            pend_min  <= inc_min    | (pend_min  & ~svc_min);
            pend_hrs  <= inc_hrs    | (pend_hrs  & ~svc_hrs);
            if (accept && preset_good) begin
                tc_q <= preset_tc;
            end else if (wr_en) begin
                tc_q <= tc_wr;
            end
            if (load_fr && (framerate != FR_RSVD)) begin
                fr_q <= framerate;
            end
            tc_update_q  <= commit;
            preset_err_q <= accept && !preset_good;
        end
    end

    assign preset_ready = ready;
    assign tc_out       = tc_q;
    assign fr_active    = fr_q;
    assign tc_update    = tc_update_q;
    assign preset_err   = preset_err_q;
    assign busy         = (state != ST_IDLE);
    assign state_dbg    = state;

endmodule

// File: tb/tb_ltc_tc_sequencer.sv
// Bench for ltc_tc_sequencer. Every tc_update is matched against the head
// of exp_q, which the scenario tasks fill as they drive stimulus.
module tb_ltc_tc_sequencer;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_FRM  = 3'd1;
    localparam logic [2:0] S_SEC  = 3'd2;
    localparam logic [2:0] S_MIN  = 3'd3;

    logic        sys_clk = 1'b0;
    logic        reset;
    logic [1:0]  framerate;
    logic        frame_tick;
    logic        preset_valid;
    logic        preset_ready;
    logic [25:0] preset_tc;
    logic        inc_sec, inc_min, inc_hrs;
    logic [25:0] tc_out;
    logic [1:0]  fr_active;
    logic        tc_update;
    logic        busy;
    logic        preset_err;
    logic [2:0]  state_dbg;

    int checks    = 0;
    int failures  = 0;
    int upd_count = 0;
    int err_count = 0;

    logic [25:0] exp_q[$];
    logic [25:0] bad_tc[5];

    // Reference timecode model, binary fields.
    int m_h, m_m, m_s, m_f;
    logic [1:0] m_fr;

    ltc_tc_sequencer #(.FR_DEFAULT(2'b01)) dut (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .framerate    (framerate),
        .frame_tick   (frame_tick),
        .preset_valid (preset_valid),
        .preset_ready (preset_ready),
        .preset_tc    (preset_tc),
        .inc_sec      (inc_sec),
        .inc_min      (inc_min),
        .inc_hrs      (inc_hrs),
        .tc_out       (tc_out),
        .fr_active    (fr_active),
        .tc_update    (tc_update),
        .busy         (busy),
        .preset_err   (preset_err),
        .state_dbg    (state_dbg)
    );

    // Clock and watchdog.
    always #5 sys_clk = ~sys_clk;

    initial begin
        #300000;
        failures++;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    function automatic logic [25:0] pack(input int h, input int m, input int s, input int f);
        return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10),
                3'(s / 10), 4'(s % 10), 2'(f / 10), 4'(f % 10)};
    endfunction

    function automatic int max_of(input logic [1:0] fr);
        if (fr == 2'b00) return 23;
        if (fr == 2'b11) return 29;
        return 24;
    endfunction

    task automatic model_tick();
        if (m_f < max_of(m_fr)) begin
            m_f++;
        end else begin
            m_f = 0;
            if (framerate != 2'b10) m_fr = framerate;
            m_s++;
            if (m_s == 60) begin
                m_s = 0;
                m_m++;
                if (m_m == 60) begin
                    m_m = 0;
                    m_h++;
                    if (m_h == 24) m_h = 0;
                end
            end
        end
    endtask

    // Scoreboard: compare every tc_update against the expected queue.
    always @(negedge sys_clk) begin
        logic [25:0] exp_tc;
        if (reset) begin
            exp_q.delete();
        end else begin
            if (tc_update) begin
                upd_count++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_update tc_out=%h expected no update", tc_out);
                end else begin
                    exp_tc = exp_q.pop_front();
                    if (tc_out !== exp_tc) begin
                        failures++;
                        $display("FAIL tc_value got=%h expected=%h", tc_out, exp_tc);
                    end
                end
                checks++;
                if (busy !== 1'b0) begin
                    failures++;
                    $display("FAIL update_while_busy busy=%b expected 0", busy);
                end
            end
            if (preset_err) err_count++;
        end
    end

    // Driver tasks. All start and end on a falling edge.
    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge sys_clk);
        while (!(exp_q.size() == 0 && busy === 1'b0 && preset_ready === 1'b1) && n < 60) begin
            @(negedge sys_clk);
            n++;
        end
        repeat (2) @(negedge sys_clk);
        checks++;
        if (n >= 60) begin
            failures++;
            $display("FAIL %s_timeout pending=%0d busy=%b expected drained", tag, exp_q.size(), busy);
            exp_q.delete();
        end
    endtask

    task automatic do_preset(input logic [25:0] v, input bit ok);
        int n;
        n = 0;
        while (preset_ready !== 1'b1 && n < 60) begin
            @(negedge sys_clk);
            n++;
        end
        checks++;
        if (n >= 60) begin
            failures++;
            $display("FAIL preset_ready_timeout ready=%b expected 1", preset_ready);
        end
        if (ok) exp_q.push_back(v);
        preset_tc    = v;
        preset_valid = 1'b1;
        @(negedge sys_clk);
        preset_valid = 1'b0;
    endtask

    // Pulse frame_tick, then watch 8 cycles: count busy cycles and record the
    // first three states after the tick has been latched.
    task automatic run_tick(output int busy_cycles, output logic [8:0] hist);
        busy_cycles = 0;
        hist        = '0;
        frame_tick  = 1'b1;
        @(negedge sys_clk);
        frame_tick  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge sys_clk);
            if (busy === 1'b1) busy_cycles++;
            if (k < 3) hist = {hist[5:0], state_dbg};
        end
    endtask

    // Scenarios.
    task automatic test_reset();
        reset = 1'b1;
        framerate = 2'b01;
        frame_tick = 0; preset_valid = 0; preset_tc = '0;
        inc_sec = 0; inc_min = 0; inc_hrs = 0;
        repeat (3) @(negedge sys_clk);
        checks++;
        if ({tc_out, fr_active, busy, tc_update, preset_err, preset_ready, state_dbg} !==
            {26'h0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE}) begin
            failures++;
            $display("FAIL reset_outputs tc=%h fr=%b busy=%b upd=%b err=%b rdy=%b st=%0d expected all zero fr=01",
                     tc_out, fr_active, busy, tc_update, preset_err, preset_ready, state_dbg);
        end
        reset = 1'b0;
        @(negedge sys_clk);
        checks++;
        if (preset_ready !== 1'b1 || tc_out !== 26'h0) begin
            failures++;
            $display("FAIL post_reset_ready rdy=%b tc=%h expected 1 and 0", preset_ready, tc_out);
        end
    endtask

    task automatic test_frame_carry();
        int bc; logic [8:0] h; int u0;
        do_preset(pack(0, 0, 0, 24), 1);
        wait_idle("carry_preset");
        u0 = upd_count;
        exp_q.push_back(pack(0, 0, 1, 0));
        run_tick(bc, h);
        wait_idle("carry");
        checks++;
        if (bc !== 2) begin
            failures++;
            $display("FAIL carry_busy_cycles got=%0d expected=2", bc);
        end
        checks++;
        if (h !== {S_FRM, S_SEC, S_IDLE}) begin
            failures++;
            $display("FAIL carry_states got=%h expected=%h", h, {S_FRM, S_SEC, S_IDLE});
        end
        checks++;
        if (upd_count - u0 !== 1) begin
            failures++;
            $display("FAIL carry_update_count got=%0d expected=1", upd_count - u0);
        end
    endtask

    task automatic test_rate_switch();
        int bc; logic [8:0] h;
        // Move to 30 fps at a second boundary.
        framerate = 2'b11;
        do_preset(pack(0, 0, 0, 24), 1);
        exp_q.push_back(pack(0, 0, 1, 0));
        run_tick(bc, h);
        wait_idle("rate30");
        checks++;
        if (fr_active !== 2'b11) begin
            failures++;
            $display("FAIL rate30_applied got=%b expected=11", fr_active);
        end
        do_preset(pack(23, 59, 59, 29), 1);
        wait_idle("wrap_preset");
        framerate = 2'b00;
        repeat (2) @(negedge sys_clk);
        checks++;
        if (fr_active !== 2'b11) begin
            failures++;
            $display("FAIL rate_mid_second got=%b expected=11", fr_active);
        end
        exp_q.push_back(pack(0, 0, 0, 0));
        run_tick(bc, h);
        wait_idle("full_wrap");
        checks++;
        if (bc !== 4) begin
            failures++;
            $display("FAIL wrap_busy_cycles got=%0d expected=4", bc);
        end
        checks++;
        if (fr_active !== 2'b00) begin
            failures++;
            $display("FAIL wrap_rate got=%b expected=00", fr_active);
        end
        // Reserved code at a boundary leaves the rate alone.
        do_preset(pack(0, 0, 0, 23), 1);
        framerate = 2'b10;
        exp_q.push_back(pack(0, 0, 1, 0));
        run_tick(bc, h);
        wait_idle("rsvd");
        checks++;
        if (fr_active !== 2'b00) begin
            failures++;
            $display("FAIL rsvd_rate got=%b expected=00", fr_active);
        end
    endtask

    task automatic test_simultaneous();
        int bc; logic [8:0] h; int u0;
        framerate = 2'b01;
        do_preset(pack(0, 0, 1, 23), 1);
        exp_q.push_back(pack(0, 0, 2, 0));
        run_tick(bc, h);
        wait_idle("back_to_25");
        do_preset(pack(0, 10, 0, 5), 1);
        wait_idle("simul_preset");
        u0 = upd_count;
        exp_q.push_back(pack(0, 10, 0, 6));
        exp_q.push_back(pack(0, 11, 0, 6));
        frame_tick = 1'b1;
        inc_min    = 1'b1;
        @(negedge sys_clk);
        frame_tick = 1'b0;
        inc_min    = 1'b0;
        wait_idle("simul");
        checks++;
        if (upd_count - u0 !== 2) begin
            failures++;
            $display("FAIL simul_update_count got=%0d expected=2", upd_count - u0);
        end
    endtask

    task automatic test_preset();
        logic [25:0] prev; int e0;
        bad_tc[0] = {6'h12, 7'h34, 7'h56, 6'h26};
        bad_tc[1] = {6'h12, 7'h34, 7'h5A, 6'h00};
        bad_tc[2] = {6'h24, 7'h00, 7'h00, 6'h00};
        bad_tc[3] = {6'h00, 7'h60, 7'h00, 6'h00};
        bad_tc[4] = {6'h00, 7'h00, 7'h00, 6'h25};
        for (int i = 0; i < 5; i++) begin
            prev = tc_out;
            e0   = err_count;
            do_preset(bad_tc[i], 0);
            repeat (3) @(negedge sys_clk);
            checks++;
            if (err_count - e0 !== 1) begin
                failures++;
                $display("FAIL preset_err_pulse idx=%0d got=%0d expected=1", i, err_count - e0);
            end
            checks++;
            if (tc_out !== prev) begin
                failures++;
                $display("FAIL preset_bad_kept idx=%0d got=%h expected=%h", i, tc_out, prev);
            end
        end
        e0 = err_count;
        do_preset(pack(12, 34, 56, 20), 1);
        wait_idle("preset_good");
        checks++;
        if (err_count !== e0) begin
            failures++;
            $display("FAIL preset_good_err got=%0d expected=%0d", err_count, e0);
        end
    endtask

    task automatic test_preset_hold();
        int low; int n;
        do_preset(pack(0, 0, 5, 10), 1);
        wait_idle("hold_setup");
        exp_q.push_back(pack(0, 0, 5, 11));
        exp_q.push_back(pack(0, 0, 8, 0));
        frame_tick = 1'b1;
        @(negedge sys_clk);
        frame_tick   = 1'b0;
        preset_tc    = pack(0, 0, 8, 0);
        preset_valid = 1'b1;
        low = 0;
        n   = 0;
        while (preset_ready !== 1'b1 && n < 20) begin
            low++;
            @(negedge sys_clk);
            n++;
        end
        @(negedge sys_clk);
        preset_valid = 1'b0;
        wait_idle("hold");
        checks++;
        if (low !== 2) begin
            failures++;
            $display("FAIL hold_ready_low got=%0d expected=2", low);
        end
    endtask

    task automatic test_inc_wrap();
        do_preset(pack(1, 2, 59, 10), 1);
        wait_idle("inc_setup");
        exp_q.push_back(pack(1, 2, 0, 10));
        inc_sec = 1'b1;
        @(negedge sys_clk);
        inc_sec = 1'b0;
        wait_idle("inc_sec");
        do_preset(pack(23, 59, 30, 0), 1);
        wait_idle("inc_setup2");
        exp_q.push_back(pack(23, 0, 30, 0));
        exp_q.push_back(pack(0, 0, 30, 0));
        inc_min = 1'b1;
        inc_hrs = 1'b1;
        @(negedge sys_clk);
        inc_min = 1'b0;
        inc_hrs = 1'b0;
        wait_idle("inc_min_hrs");
    endtask

    task automatic test_back_to_back();
        do_preset(pack(0, 0, 0, 24), 1);
        wait_idle("merge_setup");
        exp_q.push_back(pack(0, 0, 1, 0));
        exp_q.push_back(pack(0, 0, 1, 1));
        frame_tick = 1'b1;
        @(negedge sys_clk);
        frame_tick = 1'b0;
        @(negedge sys_clk);
        frame_tick = 1'b1;
        repeat (2) @(negedge sys_clk);
        frame_tick = 1'b0;
        wait_idle("merge");
    endtask

    task automatic test_random();
        framerate = 2'b01;
        m_fr = 2'b01;
        checks++;
        if (fr_active !== m_fr) begin
            failures++;
            $display("FAIL random_start_rate got=%b expected=%b", fr_active, m_fr);
        end
        for (int i = 0; i < 40; i++) begin
            if (i % 8 == 0) begin
                m_h = int'($urandom_range(23, 22));
                m_m = int'($urandom_range(59, 58));
                m_s = int'($urandom_range(59, 58));
                m_f = int'($urandom_range(max_of(m_fr), max_of(m_fr) - 1));
                do_preset(pack(m_h, m_m, m_s, m_f), 1);
            end else begin
                framerate = 2'($urandom_range(3, 0));
                model_tick();
                exp_q.push_back(pack(m_h, m_m, m_s, m_f));
                frame_tick = 1'b1;
                @(negedge sys_clk);
                frame_tick = 1'b0;
            end
            wait_idle("random");
            checks++;
            if (fr_active !== m_fr) begin
                failures++;
                $display("FAIL random_rate iter=%0d got=%b expected=%b", i, fr_active, m_fr);
            end
        end
    endtask

    task automatic test_reset_mid_chain();
        int n; int u0;
        do_preset(pack(0, 59, 59, max_of(m_fr)), 1);
        wait_idle("abort_setup");
        framerate  = 2'b11;
        frame_tick = 1'b1;
        @(negedge sys_clk);
        frame_tick = 1'b0;
        n = 0;
        while (state_dbg !== S_MIN && n < 10) begin
            @(negedge sys_clk);
            n++;
        end
        checks++;
        if (n >= 10) begin
            failures++;
            $display("FAIL abort_reach_min state=%0d expected=%0d", state_dbg, S_MIN);
        end
        reset      = 1'b1;
        frame_tick = 1'b1;
        inc_sec    = 1'b1;
        @(negedge sys_clk);
        frame_tick = 1'b0;
        inc_sec    = 1'b0;
        checks++;
        if ({tc_out, fr_active, busy, tc_update, state_dbg} !== {26'h0, 2'b01, 1'b0, 1'b0, S_IDLE}) begin
            failures++;
            $display("FAIL abort_outputs tc=%h fr=%b busy=%b upd=%b st=%0d expected 0 01 0 0 0",
                     tc_out, fr_active, busy, tc_update, state_dbg);
        end
        reset = 1'b0;
        u0    = upd_count;
        repeat (6) @(negedge sys_clk);
        checks++;
        if (upd_count !== u0 || tc_out !== 26'h0 || preset_ready !== 1'b1) begin
            failures++;
            $display("FAIL abort_pends_cleared upd=%0d tc=%h rdy=%b expected %0d 0 1",
                     upd_count, tc_out, preset_ready, u0);
        end
    endtask

    initial begin
        test_reset();
        test_frame_carry();
        test_rate_switch();
        test_simultaneous();
        test_preset();
        test_preset_hold();
        test_inc_wrap();
        test_back_to_back();
        test_random();
        test_reset_mid_chain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
